// File: rtl/spi_pkg.sv
// Shared SPI mode type and helpers for the SPI slave word receiver.
package spi_pkg;

    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_e;

    // clk_sys must run at least this many times faster than SCLK.
    localparam int unsigned SPI_MIN_OVERSAMPLE = 8;

    // Data is sampled on rising SCLK when CPOL == CPHA.
    function automatic logic sample_on_rise(spi_mode_e mode);
        logic rise;
        unique case (mode)
            MODE0, MODE3: rise = 1'b1;
            default:      rise = 1'b0;
        endcase
        return rise;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous pin, followed by an edge-detect stage.
module spi_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_slave_word_rx.sv
// SPI slave: oversampled pins, MSB-first word deserialiser with valid/ready output and MISO shifter.
// Define SPI_SLAVE_ECHO_EN to reload MISO with the word just received instead of tx_data_i.
module spi_slave_word_rx
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_sys,
    input  logic             rst_sys_n,
    input  logic             SCLK,
    input  logic             SS,
    input  logic             MOSI,
    input  logic [1:0]       MODE,
    output logic             MISO,
    input  logic [WIDTH-1:0] tx_data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             word_valid_o,
    input  logic             word_ready_i,
    output logic             word_first_o,
    output logic             frame_start_o,
    output logic             frame_end_o,
    output logic             frame_abort_o,
    output logic             overrun_o,
    output logic             busy_o
);

    localparam int unsigned CntW   = $clog2(WIDTH);
    localparam int unsigned FlushW = $clog2(SYNC_STAGES + 1) + 1;
    localparam logic [CntW-1:0]   LastBit   = CntW'(WIDTH - 1);
    localparam logic [FlushW-1:0] FlushDone = FlushW'(SYNC_STAGES);

    logic sclk_level, sclk_rise, sclk_fall;
    logic ss_level, ss_rise, ss_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic unused_pins;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk_i(clk_sys), .rst_ni(rst_sys_n), .pin_i(SCLK),
        .level_o(sclk_level), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk_i(clk_sys), .rst_ni(rst_sys_n), .pin_i(SS),
        .level_o(ss_level), .rise_o(ss_rise), .fall_o(ss_fall)
    );
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk_i(clk_sys), .rst_ni(rst_sys_n), .pin_i(MOSI),
        .level_o(mosi_level), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    assign unused_pins = ^{sclk_level, mosi_rise, mosi_fall};

    spi_mode_e mode;
    assign mode = spi_mode_e'(MODE);

    logic [WIDTH-2:0]  rx_shift_q, rx_shift_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [WIDTH-1:0]  tx_shift_q, tx_shift_d;
    logic [FlushW-1:0] flush_q, flush_d;
    logic valid_q, valid_d, first_q, first_d, first_flag_q, first_flag_d;
    logic overrun_q, overrun_d, active_q, active_d, armed_q, armed_d;
    logic hold_q, hold_d, start_q, start_d, end_q, end_d, abort_q, abort_d;

    logic             sample_rise, sample_edge, shift_edge, complete;
    logic [WIDTH-1:0] rx_word, reload_word;

    assign sample_rise = sample_on_rise(mode);
    assign sample_edge = active_q & (sample_rise ? sclk_rise : sclk_fall);
    assign shift_edge  = active_q & (sample_rise ? sclk_fall : sclk_rise);
    assign rx_word     = {rx_shift_q, mosi_level};
    assign complete    = sample_edge & (bit_cnt_q == LastBit);

`ifdef SPI_SLAVE_ECHO_EN
    assign reload_word = rx_word;
`else
    assign reload_word = tx_data_i;
`endif

    always_comb begin
        rx_shift_d   = rx_shift_q;
        bit_cnt_d    = bit_cnt_q;
        data_d       = data_q;
        tx_shift_d   = tx_shift_q;
        flush_d      = flush_q;
        valid_d      = valid_q;
        first_d      = first_q;
        first_flag_d = first_flag_q;
        overrun_d    = overrun_q;
        active_d     = active_q;
        armed_d      = armed_q;
        hold_d       = hold_q;
        start_d      = 1'b0;
        end_d        = 1'b0;
        abort_d      = 1'b0;

        // Only arm once SS has been seen inactive after reset, so a low SS is never a frame start.
        if (flush_q != FlushDone) begin
            flush_d = flush_q + 1'b1;
        end else if (ss_level) begin
            armed_d = 1'b1;
        end

        if (shift_edge) begin
            if (hold_q) begin
                hold_d = 1'b0;
            end else begin
                tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
            end
        end

        if (sample_edge) begin
            rx_shift_d = rx_word[WIDTH-2:0];
            bit_cnt_d  = complete ? '0 : bit_cnt_q + 1'b1;
        end

        if (complete) begin
            if (!valid_q || word_ready_i) begin
                data_d       = rx_word;
                valid_d      = 1'b1;
                first_d      = first_flag_q;
                first_flag_d = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
            // The next shift edge presents the new MSB rather than shifting it away.
            tx_shift_d = reload_word;
            hold_d     = 1'b1;
        end else if (word_ready_i) begin
            valid_d = 1'b0;
        end

        if (active_q && ss_rise) begin
            end_d     = 1'b1;
            abort_d   = (bit_cnt_d != '0);
            bit_cnt_d = '0;
            active_d  = 1'b0;
            hold_d    = 1'b0;
        end else if (armed_q && !active_q && ss_fall) begin
            start_d      = 1'b1;
            active_d     = 1'b1;
            first_flag_d = 1'b1;
            bit_cnt_d    = '0;
            overrun_d    = 1'b0;
            tx_shift_d   = tx_data_i;
            hold_d       = MODE[0];
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            rx_shift_q   <= '0;
            bit_cnt_q    <= '0;
            data_q       <= '0;
            tx_shift_q   <= '0;
            flush_q      <= '0;
            valid_q      <= 1'b0;
            first_q      <= 1'b0;
            first_flag_q <= 1'b0;
            overrun_q    <= 1'b0;
            active_q     <= 1'b0;
            armed_q      <= 1'b0;
            hold_q       <= 1'b0;
            start_q      <= 1'b0;
            end_q        <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            rx_shift_q   <= rx_shift_d;
            bit_cnt_q    <= bit_cnt_d;
            data_q       <= data_d;
            tx_shift_q   <= tx_shift_d;
            flush_q      <= flush_d;
            valid_q      <= valid_d;
            first_q      <= first_d;
            first_flag_q <= first_flag_d;
            overrun_q    <= overrun_d;
            active_q     <= active_d;
            armed_q      <= armed_d;
            hold_q       <= hold_d;
            start_q      <= start_d;
            end_q        <= end_d;
            abort_q      <= abort_d;
        end
    end

    assign MISO          = active_q & tx_shift_q[WIDTH-1];
    assign data_o        = data_q;
    assign word_valid_o  = valid_q;
    assign word_first_o  = first_q;
    assign frame_start_o = start_q;
    assign frame_end_o   = end_q;
    assign frame_abort_o = abort_q;
    assign overrun_o     = overrun_q;
    assign busy_o        = active_q;

endmodule

// File: tb/tb_spi_slave_word_rx.sv
// Self-checking bench for spi_slave_word_rx: behavioural SPI master plus expected-word model.
module tb_spi_slave_word_rx;

    localparam int HALF = 8;
`ifdef SPI_SLAVE_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic        clk_sys = 1'b0, rst_sys_n = 1'b0;
    logic        SCLK = 1'b0, SS = 1'b1, MOSI = 1'b0;
    logic [1:0]  MODE = 2'b00;
    logic        MISO;
    logic [31:0] tx_data_i = '0, data_o;
    logic        word_valid_o, word_ready_i = 1'b0, word_first_o;
    logic        frame_start_o, frame_end_o, frame_abort_o, overrun_o, busy_o;

    int checks = 0, errors = 0;
    int n_start = 0, n_end = 0, n_abort = 0;
    logic [31:0] acc_data[$];
    logic        acc_first[$];

    spi_slave_word_rx dut (
        .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .SCLK(SCLK), .SS(SS), .MOSI(MOSI),
        .MODE(MODE), .MISO(MISO), .tx_data_i(tx_data_i), .data_o(data_o),
        .word_valid_o(word_valid_o), .word_ready_i(word_ready_i),
        .word_first_o(word_first_o), .frame_start_o(frame_start_o),
        .frame_end_o(frame_end_o), .frame_abort_o(frame_abort_o),
        .overrun_o(overrun_o), .busy_o(busy_o)
    );

    always #5 clk_sys = ~clk_sys;

    // Passive monitor: frame pulses and every accepted handshake.
    always @(negedge clk_sys) begin
        if (frame_start_o) n_start <= n_start + 1;
        if (frame_end_o)   n_end   <= n_end + 1;
        if (frame_abort_o) n_abort <= n_abort + 1;
        if (word_valid_o && word_ready_i) begin
            acc_data.push_back(data_o);
            acc_first.push_back(word_first_o);
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp_w, input logic exp_first);
        checks++;
        assert (acc_data.size() != 0) else begin
            errors++;
            $error("FAIL %s: got no word expected 0x%08h", tag, exp_w);
        end
        if (acc_data.size() != 0) begin
            chk({tag, "_data"}, acc_data.pop_front(), exp_w);
            chk({tag, "_first"}, 32'(acc_first.pop_front()), 32'(exp_first));
        end
    endtask

    task automatic check_idle(input string pfx);
        chk({pfx, "_data"}, data_o, 32'h0);
        chk({pfx, "_outs"},
            {24'h0, word_valid_o, word_first_o, frame_start_o, frame_end_o,
             frame_abort_o, overrun_o, busy_o, MISO}, 32'h0);
    endtask

    // SPI master: clocks nbits of w MSB-first and returns what it sampled on MISO.
    task automatic xfer(input logic [31:0] w, input int nbits, output logic [31:0] rd);
        logic cpol, cpha;
        cpol = MODE[1];
        cpha = MODE[0];
        rd   = '0;
        for (int i = 31; i > 31 - nbits; i--) begin
            if (!cpha) begin
                MOSI = w[i];
                wait_clk(HALF);
                rd   = {rd[30:0], MISO};
                SCLK = ~cpol;
                wait_clk(HALF);
                SCLK = cpol;
            end else begin
                SCLK = ~cpol;
                MOSI = w[i];
                wait_clk(HALF);
                rd   = {rd[30:0], MISO};
                SCLK = cpol;
                wait_clk(HALF);
            end
        end
    endtask

    task automatic ss_start();
        SS = 1'b0;
        wait_clk(6);
    endtask

    task automatic ss_stop();
        wait_clk(6);
        SS = 1'b1;
        wait_clk(12);
    endtask

    task automatic set_mode(input logic [1:0] m);
        MODE = m;
        SCLK = m[1];
        wait_clk(8);
    endtask

    initial begin
        logic [31:0] rd, rd2, w, w2, tx;
        logic [31:0] words[3];
        int s_start, s_end, s_abort, nw;

        wait_clk(3);
        check_idle("reset_held");
        rst_sys_n = 1'b1;
        wait_clk(6);
        check_idle("reset_rel");

        // Single word, ready held high.
        set_mode(2'b01);
        word_ready_i = 1'b1;
        tx = $urandom;
        tx_data_i = tx;
        s_start = n_start; s_end = n_end; s_abort = n_abort;
        ss_start();
        chk("t1_busy", 32'(busy_o), 32'h1);
        xfer(32'hDEADBEEF, 32, rd);
        ss_stop();
        chk("t1_count", acc_data.size(), 1);
        pop_chk("t1_word", 32'hDEADBEEF, 1'b1);
        chk("t1_starts", n_start - s_start, 1);
        chk("t1_ends", n_end - s_end, 1);
        chk("t1_aborts", n_abort - s_abort, 0);
        chk("t1_overrun", 32'(overrun_o), 32'h0);
        chk("t1_miso_rd", rd, tx);
        chk("t1_miso_idle", 32'(MISO), 32'h0);

        // Two words with consumer stalled: second dropped, overrun sticky.
        word_ready_i = 1'b0;
        tx = $urandom;
        tx_data_i = tx;
        ss_start();
        xfer(32'h00000100, 32, rd);
        xfer(32'h12345678, 32, rd2);
        ss_stop();
        chk("t2_valid", 32'(word_valid_o), 32'h1);
        chk("t2_data", data_o, 32'h00000100);
        chk("t2_first", 32'(word_first_o), 32'h1);
        chk("t2_overrun", 32'(overrun_o), 32'h1);
        chk("t2_miso0", rd, tx);
        chk("t2_miso1", rd2, ECHO ? 32'h00000100 : tx);
        word_ready_i = 1'b1;
        wait_clk(1);
        chk("t2_valid_drop", 32'(word_valid_o), 32'h0);
        pop_chk("t2_word", 32'h00000100, 1'b1);
        chk("t2_overrun_held", 32'(overrun_o), 32'h1);
        w = $urandom;
        ss_start();
        chk("t2_overrun_clr", 32'(overrun_o), 32'h0);
        xfer(w, 32, rd);
        ss_stop();
        pop_chk("t2_next", w, 1'b1);

        // Partial word aborted.
        s_end = n_end; s_abort = n_abort;
        ss_start();
        xfer($urandom, 13, rd);
        ss_stop();
        chk("t3_aborts", n_abort - s_abort, 1);
        chk("t3_ends", n_end - s_end, 1);
        chk("t3_no_word", acc_data.size(), 0);
        w = $urandom;
        ss_start();
        xfer(w, 32, rd);
        ss_stop();
        chk("t3_aborts_after", n_abort - s_abort, 1);
        pop_chk("t3_next", w, 1'b1);

        // MISO readback in modes 0 and 3.
        for (int m = 0; m < 4; m += 3) begin
            set_mode(2'(m));
            tx_data_i = 32'hA5A50001;
            w = $urandom;
            ss_start();
            xfer(w, 32, rd);
            ss_stop();
            chk($sformatf("t4_m%0d_miso", m), rd, 32'hA5A50001);
            pop_chk($sformatf("t4_m%0d_word", m), w, 1'b1);
            chk($sformatf("t4_m%0d_idle", m), 32'(MISO), 32'h0);
        end

        // Reset in the middle of a frame.
        set_mode(2'b01);
        ss_start();
        xfer($urandom, 20, rd);
        rst_sys_n = 1'b0;
        wait_clk(2);
        check_idle("t5_in_reset");
        rst_sys_n = 1'b1;
        s_start = n_start; s_end = n_end; s_abort = n_abort;
        wait_clk(12);
        chk("t5_busy_low_ss", 32'(busy_o), 32'h0);
        ss_stop();
        chk("t5_no_start", n_start - s_start, 0);
        chk("t5_no_end", n_end - s_end, 0);
        chk("t5_no_word", acc_data.size(), 0);
        ss_start();
        xfer(32'hCAFEF00D, 32, rd);
        ss_stop();
        pop_chk("t5_next", 32'hCAFEF00D, 1'b1);

        // Back-to-back words and MISO reload source.
        tx = $urandom;
        tx_data_i = tx;
        ss_start();
        xfer(32'h11111111, 32, rd);
        xfer(32'h22222222, 32, rd2);
        ss_stop();
        chk("t6_miso0", rd, tx);
        chk("t6_miso1", rd2, ECHO ? 32'h11111111 : tx);
        pop_chk("t6_w0", 32'h11111111, 1'b1);
        pop_chk("t6_w1", 32'h22222222, 1'b0);

        // Random frames: random mode, 1..3 words each.
        for (int f = 0; f < 4; f++) begin
            set_mode(2'($urandom_range(0, 3)));
            tx = $urandom;
            tx_data_i = tx;
            nw = $urandom_range(1, 3);
            ss_start();
            for (int k = 0; k < nw; k++) begin
                words[k] = $urandom;
                xfer(words[k], 32, w2);
                chk($sformatf("t7_f%0d_miso%0d", f, k), w2,
                    (ECHO && k > 0) ? words[k-1] : tx);
            end
            ss_stop();
            for (int k = 0; k < nw; k++) begin
                pop_chk($sformatf("t7_f%0d_w%0d", f, k), words[k], k == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_word_rx.md
Name: spi_slave_word_rx

Overview:
- SPI slave front-end that sits directly upstream of the RAM configurator on the Zedboard top.
- Oversamples the external SCLK/SS/MOSI pins in the clk_sys domain and deserialises MSB-first words.
- Presents each word on a valid/ready handshake, tagged with frame information; the configurator consumes these words to build RAM address/data writes.
- Shifts a status or echo word out on MISO.

Parameters:
- WIDTH, 32, word length in bits; must be at least 8.
- SYNC_STAGES, 2, flops per pin synchroniser; must be at least 2.

Ports:
- clk_sys  in  1  system clock; must run at least 8x the SCLK frequency.
- rst_sys_n  in  1  asynchronous active-low reset.
- SCLK  in  1  SPI clock pin, asynchronous.
- SS  in  1  SPI slave select pin, active low, asynchronous.
- MOSI  in  1  SPI data in, asynchronous.
- MODE  in  2  {CPOL,CPHA}; must be stable while SS is high.
- MISO  out  1  SPI data out; 0 when SS is inactive.
- tx_data_i  in  WIDTH  word shifted out on MISO.
- data_o  out  WIDTH  received word.
- word_valid_o  out  1  data_o holds an unconsumed word.
- word_ready_i  in  1  consumer accepts the word.
- word_first_o  out  1  data_o is the first word of its frame.
- frame_start_o  out  1  one-cycle pulse when SS asserts.
- frame_end_o  out  1  one-cycle pulse when SS deasserts.
- frame_abort_o  out  1  one-cycle pulse when SS deasserts with a partial word pending.
- overrun_o  out  1  sticky: a completed word was dropped in this frame.
- busy_o  out  1  SS is active (synchronised).

Behaviour:
- Reset values:
  - All outputs are 0.
  - Synchroniser regs reset to SCLK=0, SS=1, MOSI=0.
  - bit_cnt=0, tx shift register=0.
- Synchronisation and edge detection:
  - Each pin passes through SYNC_STAGES flops, then one extra flop for edge detection.
  - Latency from a pin edge to internal action is SYNC_STAGES+1 clk_sys cycles.
- Sample and shift edges:
  - Sample edge is rising SCLK when CPOL^CPHA=0, otherwise falling SCLK.
  - The shift edge is the opposite SCLK edge.
  - SCLK edges are ignored while SS is high.
- Receive:
  - On a sample edge: rx_shift = {rx_shift[WIDTH-2:0], MOSI_sync}; bit_cnt++.
  - When bit_cnt reaches WIDTH-1 on a sample edge, the word completes and bit_cnt wraps to 0.
- Word completion:
  - If word_valid_o=0 or word_ready_i=1 in that cycle: data_o loads the word, word_valid_o=1, word_first_o=first_flag, first_flag clears.
  - Otherwise the word is dropped, overrun_o is set, and data_o, word_valid_o and word_first_o are unchanged.
- Handshake:
  - word_valid_o clears on word_ready_i when no completion occurs in the same cycle.
  - data_o is stable while valid && !ready.
- Frame start (SS falling):
  - frame_start_o pulses.
  - first_flag=1, bit_cnt=0, overrun_o clears.
  - tx_shift loads tx_data_i.
- Frame end (SS rising):
  - frame_end_o pulses.
  - If bit_cnt!=0, frame_abort_o pulses in the same cycle and the partial word is discarded.
  - bit_cnt=0.
  - A pending word_valid_o is kept.
- Same-cycle sample edge and SS rise: the sample edge is processed first, which can complete a word; end/abort are then evaluated on the updated bit_cnt.
- Transmit:
  - MISO = tx_shift[WIDTH-1] while busy_o, else 0.
  - On a shift edge, tx_shift shifts left with 0 fill.
  - When CPHA=1, the first shift edge of a frame does not shift, so the MSB is presented for the first sample.
  - On word completion, tx_shift reloads with the reload source for the next word.
- Reset mid-frame: all state returns to reset values. Reception resumes at the next SS falling edge only; an already-low SS is not treated as a frame start.

Optional Feature:
- Macro: SPI_SLAVE_ECHO_EN.
- Defined: the reload source at word completion is the word just received, so the master reads back word N during word N+1. The first word of a frame still comes from tx_data_i.
- Undefined: the reload source is always tx_data_i.

Decomposition:
- spi_pkg holds:
  - spi_mode_e typedef: MODE0..MODE3.
  - Function sample_on_rise(mode).
  - Constant SPI_MIN_OVERSAMPLE=8.
- Sub-module spi_pin_sync: per-pin SYNC_STAGES synchroniser plus rise/fall edge detect, instantiated three times.

Test Plan:
- MODE=2'b01: send 0xDEADBEEF with word_ready_i=1 -> one word_valid_o pulse, data_o=0xDEADBEEF, word_first_o=1, frame_start_o/frame_end_o each pulse once, overrun_o=0.
- MODE=2'b01: two words 0x00000100 then 0x12345678 with word_ready_i=0 -> data_o stays 0x00000100, overrun_o=1; then ready=1 -> valid drops; the next frame clears overrun_o.
- SS deasserted after 13 bits -> frame_abort_o pulses, no word_valid_o; the next full frame yields the correct word with word_first_o=1.
- MODE=2'b00 and 2'b11: tx_data_i=0xA5A50001 -> the master samples 0xA5A50001 on MISO; MISO=0 with SS high.
- rst_sys_n asserted after 20 bits with SS still low -> all outputs 0, no word at SS release; the next frame receives 0xCAFEF00D correctly.
- SPI_SLAVE_ECHO_EN defined: words 0x11111111, 0x22222222 -> MISO returns tx_data_i then 0x11111111.
